ram_bank: RTL and testbench

- Parametrised single-port data RAM bank for the RISC-V core's data bus, replacing the fixed 256-word combinational-read RAM.
- Adds byte-lane write strobes, a req/gnt/rvalid handshake, a registered read path, programmable wait states and an address-range error response.
- Sits between the core's LSU/bus interconnect and on-chip storage.
- Holds one outstanding transaction; sustains one transaction per cycle when WAIT_STATES=0.

---
 rtl/ram_bank_pkg.sv | 23 ++
 rtl/ram_bank_array.sv | 28 ++
 rtl/ram_bank.sv | 109 ++++++++++
 tb/tb_ram_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared constants, FSM encoding and helpers for the ram_bank data RAM.
package ram_bank_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [WORD_W-1:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic              WRITE_ENABLE = 1'b1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Ceiling log2, usable in constant expressions for index widths.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

endpackage

// File: rtl/ram_bank_array.sv
// DEPTH x 32 storage with byte-lane writes and a registered read; no reset so it maps to block RAM.
module ram_bank_array
  import ram_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < int'(BE_W); k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/ram_bank.sv
// Single-port data RAM bank: req/gnt/rvalid handshake, wait states and address-range error response.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = clog2(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              in_range;
  logic [31:0]       offset;
  logic [IDX_W-1:0]  idx;
  logic              wr_en, rd_en;
  logic [WORD_W-1:0] arr_rdata;
  logic              err_pend_q, rd_pend_q, rd_ok_q;
  logic              resp_d;

  assign gnt_o    = (state_q != S_WAIT);
  assign accept   = req_i && gnt_o;
  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = offset < 32'(DEPTH * 4);
  assign idx      = offset[IDX_W+1:2];
  assign wr_en    = accept && (we_i == WRITE_ENABLE) && in_range;
  assign rd_en    = accept && (we_i != WRITE_ENABLE) && in_range;

  ram_bank_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .idx   (idx),
    .wr_en (wr_en),
    .be    (be_i),
    .wdata (wdata_i),
    .rd_en (rd_en),
    .rdata (arr_rdata)
  );

  // Next-state logic; RESP can accept again for back-to-back traffic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_d = (state_d == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_ok_q    <= 1'b0;
      rvalid_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_o <= resp_d;
      if (accept) begin
        err_pend_q <= !in_range;
        rd_pend_q  <= rd_en;
      end
      // With no wait states the response follows the accept edge directly.
      err_o   <= resp_d && (accept ? !in_range : err_pend_q);
      rd_ok_q <= resp_d && (accept ? rd_en : rd_pend_q);
    end
  end

  assign rdata_o = rd_ok_q ? arr_rdata : ZERO_WORD;

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank: one zero-wait instance with a small offset window, one three-wait instance.
module tb_ram_bank;

  localparam int unsigned WS_A = 0;
  localparam int unsigned WS_B = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic sel, req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic gnt, rvalid, err;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mdl [2][1024];
  logic [31:0] got_d;
  logic        got_e;
  logic        e_err;
  logic [31:0] e_rd;

  always #5 clk = ~clk;

  ram_bank #(.DEPTH(16), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(WS_A)) u_a (
    .clk(clk), .rst_n(rst_n), .req_i(req && !sel), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .rdata_o(rdata_a), .err_o(err_a));

  ram_bank #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(WS_B)) u_b (
    .clk(clk), .rst_n(rst_n), .req_i(req && sel), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .rdata_o(rdata_b), .err_o(err_b));

  assign gnt    = sel ? gnt_b    : gnt_a;
  assign rvalid = sel ? rvalid_b : rvalid_a;
  assign rdata  = sel ? rdata_b  : rdata_a;
  assign err    = sel ? err_b    : err_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: window test on byte addresses, byte-lane merge, writes commit at accept.
  task automatic model_access(input logic s, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              output logic o_err, output logic [31:0] o_rd);
    longint unsigned base, lim;
    int unsigned wi;
    base = s ? 64'h0 : 64'h1000;
    lim  = base + (s ? 64'd4096 : 64'd64);
    o_rd = 32'h0;
    if (64'(a) >= base && 64'(a) < lim) begin
      o_err = 1'b0;
      wi = int'((64'(a) - base) / 4);
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) mdl[s][wi][8*k +: 8] = d[8*k +: 8];
      end else begin
        o_rd = mdl[s][wi];
      end
    end else begin
      o_err = 1'b1;
    end
  endtask

  // One transaction from an idle bank; requests raised during wait states must be ignored.
  task automatic txn(input logic s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    int unsigned ws;
    ws = s ? WS_B : WS_A;
    @(negedge clk);
    sel = s;
    #1;
    check("idle_gnt", 32'(gnt), 32'd1);
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_rdata", rdata, 32'h0);
    check("idle_err", 32'(err), 32'd0);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    model_access(s, w, a, d, b, e_err, e_rd);
    for (int c = 1; c <= int'(ws) + 1; c++) begin
      @(negedge clk);
      if (c == int'(ws) + 1) begin
        check("resp_rvalid", 32'(rvalid), 32'd1);
        check("resp_err", 32'(err), 32'(e_err));
        check("resp_rdata", rdata, e_rd);
        got_d = rdata;
        got_e = err;
        req = 1'b0;
      end else begin
        check("wait_gnt", 32'(gnt), 32'd0);
        check("wait_rvalid", 32'(rvalid), 32'd0);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = $urandom; be = 4'hF;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_gnt", 32'(gnt), 32'd1);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_err", 32'(err), 32'd0);
    end

    // Fill both model-tracked regions with known data.
    for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 64; i++) txn(1'b1, 1'b1, 32'(4 * i), $urandom, 4'hF);

    // Back-to-back write then read of the same word, zero wait states.
    @(negedge clk);
    sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h1010; wdata = 32'hDEAD_BEEF; be = 4'hF;
    model_access(1'b0, 1'b1, addr, wdata, be, e_err, e_rd);
    @(negedge clk);
    check("b2b_wr_rvalid", 32'(rvalid), 32'd1);
    check("b2b_wr_rdata", rdata, 32'h0);
    check("b2b_gnt", 32'(gnt), 32'd1);
    we = 1'b0;
    model_access(1'b0, 1'b0, addr, wdata, be, e_err, e_rd);
    @(negedge clk);
    check("b2b_rd_rvalid", 32'(rvalid), 32'd1);
    check("b2b_rd_err", 32'(err), 32'd0);
    check("b2b_rd_rdata", rdata, 32'hDEAD_BEEF);
    req = 1'b0;
    @(negedge clk);
    check("b2b_idle_rvalid", 32'(rvalid), 32'd0);
    check("b2b_idle_rdata", rdata, 32'h0);

    // Byte lanes.
    txn(1'b0, 1'b1, 32'h1020 - 32'h1000 + 32'h1000 - 32'h0 + 32'h0, 32'h1122_3344, 4'hF);
    txn(1'b0, 1'b1, 32'h1020, 32'hAABB_CCDD, 4'b0101);
    txn(1'b0, 1'b0, 32'h1022, 32'h0, 4'h0);
    check("lanes_rdata", got_d, 32'h11BB_33DD);
    txn(1'b0, 1'b1, 32'h1020, 32'hFFFF_FFFF, 4'b0000);
    txn(1'b0, 1'b0, 32'h1020, 32'h0, 4'h0);
    check("lanes_none", got_d, 32'h11BB_33DD);

    // Address range on the 16-word window at 0x1000.
    txn(1'b0, 1'b1, 32'h1040, 32'h5555_5555, 4'hF);
    check("oor_wr_err", 32'(got_e), 32'd1);
    txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0);
    check("oor_no_alias", got_d, mdl[0][0]);
    txn(1'b0, 1'b0, 32'h0FFC, 32'h0, 4'h0);
    check("below_base_err", 32'(got_e), 32'd1);
    check("below_base_rdata", got_d, 32'h0);
    txn(1'b0, 1'b0, 32'h103C, 32'h0, 4'h0);
    check("top_word_err", 32'(got_e), 32'd0);

    // Three wait states, with stray requests during the wait.
    txn(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    check("ws3_rdata", got_d, 32'hDEAD_BEEF);

    // Reset one cycle after accepting a write, then after accepting a read.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      sel = 1'b1; req = 1'b1; we = (r == 0); addr = 32'h40; wdata = 32'hCAFE_F00D; be = 4'hF;
      model_access(1'b1, we, addr, wdata, be, e_err, e_rd);
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_gnt", 32'(gnt), 32'd1);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check("post_rst_no_rvalid", 32'(rvalid), 32'd0);
      end
    end
    txn(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    check("rst_write_kept", got_d, 32'hCAFE_F00D);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra;
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = 32'h1000 - 32'(4 * $urandom_range(1, 4));
        default: ra = 32'h1000 + 32'($urandom_range(0, 63));
      endcase
      txn(1'b0, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 32'h1000 + 32'($urandom_range(0, 4095))
                                       : 32'($urandom_range(0, 255));
      txn(1'b1, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
